nts_engine_dispatch_arbiter: RTL and testbench



---
 rtl/nts_engine_dispatch_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_nts_engine_dispatch_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nts_engine_dispatch_arbiter.sv
// Dispatch arbiter: shares one dispatcher receive FIFO among NUM_ENGINES engines.
// Each packet is granted to an idle engine chosen round-robin. The FIFO read handshake is
// routed to that engine alone. If no engine frees up in time, the packet is discarded.
module nts_engine_dispatch_arbiter #(
  parameter int unsigned NUM_ENGINES     = 4,
  parameter int unsigned ENGINE_ID_WIDTH = 2,
  parameter int unsigned IDLE_TIMEOUT    = 64,
  parameter int unsigned ACCEPT_TIMEOUT  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_dispatch_packet_available,
  input  logic                       i_dispatch_fifo_empty,
  input  logic [7:0]                 i_dispatch_data_valid,
  input  logic [63:0]                i_dispatch_fifo_rd_data,
  output logic                       o_dispatch_fifo_rd_en,
  output logic                       o_dispatch_packet_read_discard,
  input  logic [NUM_ENGINES-1:0]     i_engine_busy,
  input  logic [NUM_ENGINES-1:0]     i_engine_fifo_rd_en,
  input  logic [NUM_ENGINES-1:0]     i_engine_packet_read_discard,
  output logic [NUM_ENGINES-1:0]     o_engine_packet_available,
  output logic [NUM_ENGINES-1:0]     o_engine_fifo_empty,
  output logic [7:0]                 o_engine_data_valid,
  output logic [63:0]                o_engine_fifo_rd_data,
  output logic                       o_grant_valid,
  output logic [ENGINE_ID_WIDTH-1:0] o_grant_id,
  output logic [31:0]                o_drop_count,
  output logic                       o_error
);

  localparam int unsigned WaitW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned AccW  = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(IDLE_TIMEOUT);
  localparam logic [AccW-1:0]  AccMax  = AccW'(ACCEPT_TIMEOUT);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSelect  = 3'd1;
  localparam logic [2:0] StAccept  = 3'd2;
  localparam logic [2:0] StCopy    = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [ENGINE_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ENGINE_ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic                       grant_valid_q, grant_valid_d;
  logic [WaitW-1:0]           wait_cnt_q, wait_cnt_d, wait_inc;
  logic [AccW-1:0]            acc_cnt_q, acc_cnt_d, acc_inc;
  logic [31:0]                drop_q, drop_d;
  logic                       error_q, error_d;
  logic                       discard_q, discard_d;

  logic                       sel_found;
  logic [ENGINE_ID_WIDTH-1:0] sel_id;
  logic [ENGINE_ID_WIDTH-1:0] cand;
  logic                       g_rd_en;

  assign wait_inc = wait_cnt_q + WaitW'(1);
  assign acc_inc  = acc_cnt_q + AccW'(1);
  assign g_rd_en  = i_engine_fifo_rd_en[grant_id_q];

  // Round-robin scan: first idle engine after the last grant, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_ENGINES; i++) begin
      cand = ENGINE_ID_WIDTH'((32'(ptr_q) + i) % NUM_ENGINES);
      if (!sel_found && !i_engine_busy[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Next-state logic for grant lifecycle, timeouts and counters.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    wait_cnt_d    = wait_cnt_q;
    acc_cnt_d     = acc_cnt_q;
    drop_d        = drop_q;
    error_d       = error_q;
    discard_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_dispatch_packet_available && !i_dispatch_fifo_empty) begin
          state_d    = StSelect;
          wait_cnt_d = '0;
        end
      end
      StSelect: begin
        if (!i_dispatch_packet_available) begin
          state_d = StIdle;
        end else if (sel_found) begin
          grant_id_d    = sel_id;
          ptr_d         = sel_id;
          grant_valid_d = 1'b1;
          acc_cnt_d     = '0;
          state_d       = StAccept;
        end else if (wait_inc == WaitMax) begin
          discard_d = 1'b1;
          if (drop_q != 32'hFFFF_FFFF) drop_d = drop_q + 32'd1;
          state_d   = StRelease;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      StAccept: begin
        if (!i_dispatch_packet_available) begin
          grant_valid_d = 1'b0;
          state_d       = StIdle;
        end else if (i_engine_busy[grant_id_q]) begin
          state_d = StCopy;
        end else if (acc_inc == AccMax) begin
          // Engine never accepted: flag it and free the packet; not a drop.
          error_d       = 1'b1;
          discard_d     = 1'b1;
          grant_valid_d = 1'b0;
          state_d       = StRelease;
        end else begin
          acc_cnt_d = acc_inc;
        end
      end
      StCopy: begin
        if (i_dispatch_fifo_empty && !g_rd_en) begin
          grant_valid_d = 1'b0;
          state_d       = StRelease;
        end
      end
      StRelease: begin
        // Hold until the dispatcher withdraws the packet so it is not granted twice.
        if (!i_dispatch_packet_available) state_d = StIdle;
      end
      default: begin
        state_d       = StIdle;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= StIdle;
      ptr_q         <= ENGINE_ID_WIDTH'(NUM_ENGINES - 1);
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      wait_cnt_q    <= '0;
      acc_cnt_q     <= '0;
      drop_q        <= '0;
      error_q       <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      wait_cnt_q    <= wait_cnt_d;
      acc_cnt_q     <= acc_cnt_d;
      drop_q        <= drop_d;
      error_q       <= error_d;
      discard_q     <= discard_d;
    end
  end

  // Routing: only the granted engine sees the FIFO; everyone else sees it empty.
  always_comb begin
    o_engine_packet_available = '0;
    o_engine_fifo_empty       = '1;
    if (grant_valid_q) begin
      o_engine_packet_available[grant_id_q] = i_dispatch_packet_available;
      o_engine_fifo_empty[grant_id_q]       = i_dispatch_fifo_empty;
    end
  end

  assign o_dispatch_fifo_rd_en = grant_valid_q && (state_q == StAccept || state_q == StCopy)
                                 && g_rd_en;
  assign o_dispatch_packet_read_discard = discard_q ||
                                          (state_q == StCopy &&
                                           i_engine_packet_read_discard[grant_id_q]);
  // Data is passed through unregistered so engine write timing is unchanged.
  assign o_engine_data_valid   = i_dispatch_data_valid;
  assign o_engine_fifo_rd_data = i_dispatch_fifo_rd_data;
  assign o_grant_valid         = grant_valid_q;
  assign o_grant_id            = grant_id_q;
  assign o_drop_count          = drop_q;
  assign o_error               = error_q;

endmodule

// File: tb/tb_nts_engine_dispatch_arbiter.sv
// Self-checking bench for nts_engine_dispatch_arbiter: directed scenarios plus randomized
// packets checked against a round-robin reference model.
module tb_nts_engine_dispatch_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         avail, empty;
  logic [7:0]   dv;
  logic [63:0]  rdata;
  logic         o_rd_en, o_discard;
  logic [N-1:0] busy, erd, edisc;
  logic [N-1:0] o_avail, o_empty;
  logic [7:0]   o_dv;
  logic [63:0]  o_rdata;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [31:0]  drop_count;
  logic         error;

  int tests_run = 0;
  int tests_failed = 0;
  int model_ptr = N - 1;

  always #5 clk = ~clk;

  nts_engine_dispatch_arbiter dut (
    .i_clk                          (clk),
    .i_reset_n                      (rst_n),
    .i_dispatch_packet_available    (avail),
    .i_dispatch_fifo_empty          (empty),
    .i_dispatch_data_valid          (dv),
    .i_dispatch_fifo_rd_data        (rdata),
    .o_dispatch_fifo_rd_en          (o_rd_en),
    .o_dispatch_packet_read_discard (o_discard),
    .i_engine_busy                  (busy),
    .i_engine_fifo_rd_en            (erd),
    .i_engine_packet_read_discard   (edisc),
    .o_engine_packet_available      (o_avail),
    .o_engine_fifo_empty            (o_empty),
    .o_engine_data_valid            (o_dv),
    .o_engine_fifo_rd_data          (o_rdata),
    .o_grant_valid                  (grant_valid),
    .o_grant_id                     (grant_id),
    .o_drop_count                   (drop_count),
    .o_error                        (error)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: first engine not busy, scanning forward from the last granted one.
  function automatic int model_pick(input logic [N-1:0] bsy);
    for (int k = 1; k <= N; k++) begin
      int e;
      e = (model_ptr + k) % N;
      if (!bsy[e]) return e;
    end
    return -1;
  endfunction

  // Plays one packet as dispatcher + engine; reports what was observed.
  task automatic run_packet(input logic [N-1:0] busy_bg, input int nwords,
                            input logic [N-1:0] noise, output int gid, output int rd_cnt,
                            output int bad_route, output bit granted);
    int remaining;
    gid = -1; rd_cnt = 0; bad_route = 0; granted = 0;
    busy = busy_bg; erd = '0; avail = 1'b1; empty = 1'b0;
    for (int c = 0; c < 200 && !granted; c++) begin
      cycle();
      if (grant_valid === 1'b1) granted = 1;
    end
    if (granted) begin
      gid = int'(grant_id);
      remaining = nwords;
      busy[gid] = 1'b1;
      for (int c = 0; c < 100; c++) begin
        erd = noise & N'($urandom);
        erd[gid] = (remaining > 0);
        empty = (remaining == 0);
        dv = 8'($urandom);
        rdata = {$urandom, $urandom};
        #1;
        if (o_rd_en !== erd[gid]) bad_route++;
        if (o_rdata !== rdata || o_dv !== dv) bad_route++;
        for (int j = 0; j < N; j++) begin
          if (j != gid && (o_avail[j] !== 1'b0 || o_empty[j] !== 1'b1)) bad_route++;
        end
        if (o_avail[gid] !== 1'b1 || o_empty[gid] !== empty) bad_route++;
        if (o_rd_en === 1'b1) rd_cnt++;
        if (erd[gid]) remaining--;
        cycle();
        if (grant_valid !== 1'b1) break;
      end
    end
    avail = 1'b0; empty = 1'b1; erd = '0;
    cycle();
    busy = busy_bg;
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; avail = 1'b0; empty = 1'b1; dv = '0; rdata = '0;
    busy = '0; erd = '0; edisc = '0;
    cycle();
    cycle();
    rst_n = 1'b1;
    model_ptr = N - 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_grant: got valid=%b id=%0d, want 0/0", grant_valid, grant_id);
    end
    tests_run++;
    if (drop_count !== 32'd0 || error !== 1'b0 || o_discard !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_status: got drop=%0d err=%b disc=%b, want 0", drop_count, error,
               o_discard);
    end
    tests_run++;
    if (o_avail !== 4'h0 || o_empty !== 4'hF || o_rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_route: got avail=%h empty=%h rd=%b, want 0/F/0", o_avail, o_empty,
               o_rd_en);
    end
  endtask

  task automatic test_back_to_back();
    int gid, rd_cnt, bad;
    bit granted;
    for (int p = 0; p < 3; p++) begin
      run_packet('0, 5, '0, gid, rd_cnt, bad, granted);
      tests_run++;
      if (!granted || gid != p) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d]: got %0d, want %0d", p, gid, p);
      end
      tests_run++;
      if (rd_cnt != 5 || bad != 0) begin
        tests_failed++;
        $display("FAIL b2b_reads[%0d]: got rd=%0d bad=%0d, want 5/0", p, rd_cnt, bad);
      end
      model_ptr = p;
    end
    tests_run++;
    if (drop_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_drop: got %0d, want 0", drop_count);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] masks [3];
    int want [3];
    int gid, rd_cnt, bad;
    bit granted;
    masks[0] = 4'b1000; want[0] = 0;
    masks[1] = 4'b0110; want[1] = 3;
    masks[2] = 4'b0000; want[2] = 0;
    for (int p = 0; p < 3; p++) begin
      run_packet(masks[p], 2, '0, gid, rd_cnt, bad, granted);
      tests_run++;
      if (!granted || gid != want[p] || rd_cnt != 2 || bad != 0) begin
        tests_failed++;
        $display("FAIL wrap[%0d]: got id=%0d rd=%0d bad=%0d, want id=%0d rd=2 bad=0", p, gid,
                 rd_cnt, bad, want[p]);
      end
      model_ptr = want[p];
    end
  endtask

  task automatic test_idle_timeout();
    int pulses = 0, first = -1, gv = 0;
    logic [31:0] d0;
    d0 = drop_count;
    busy = '1; avail = 1'b1; empty = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      cycle();
      if (o_discard === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (grant_valid !== 1'b0) gv++;
    end
    tests_run++;
    if (pulses != 1 || first != 65) begin
      tests_failed++;
      $display("FAIL idle_timeout_pulse: got %0d pulses first@%0d, want 1 @65", pulses, first);
    end
    tests_run++;
    if (drop_count !== d0 + 32'd1 || gv != 0) begin
      tests_failed++;
      $display("FAIL idle_timeout_drop: got drop=%0d grants=%0d, want %0d/0", drop_count, gv,
               d0 + 1);
    end
    avail = 1'b0; empty = 1'b1;
    cycle();
    cycle();
    busy = '0;
  endtask

  task automatic test_accept_timeout();
    int exp_id, gid = -1, gv_at = -1, err_at = -1, pulses = 0;
    logic [31:0] d0;
    d0 = drop_count;
    exp_id = model_pick('0);
    busy = '0; avail = 1'b1; empty = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (gv_at < 0 && grant_valid === 1'b1) begin
        gv_at = k;
        gid = int'(grant_id);
      end
      if (err_at < 0 && error === 1'b1) err_at = k;
      if (o_discard === 1'b1) pulses++;
    end
    tests_run++;
    if (gid != exp_id || gv_at < 0 || err_at - gv_at != 4) begin
      tests_failed++;
      $display("FAIL accept_timeout: got id=%0d grant@%0d err@%0d, want id=%0d err 4 later",
               gid, gv_at, err_at, exp_id);
    end
    tests_run++;
    if (pulses != 1 || drop_count !== d0 || error !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_discard: got pulses=%0d drop=%0d err=%b, want 1/%0d/1", pulses,
               drop_count, error, d0);
    end
    model_ptr = exp_id;
    avail = 1'b0; empty = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid_copy();
    bit got = 0;
    int g = 0, gid, rd_cnt, bad;
    bit granted;
    busy = '0; avail = 1'b1; empty = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      cycle();
      if (grant_valid === 1'b1) got = 1;
    end
    if (got) g = int'(grant_id);
    busy[g] = 1'b1; erd[g] = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if (!got || o_rd_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL copy_before_reset: got grant=%b rd=%b, want 1/1", got, o_rd_en);
    end
    rst_n = 1'b0;
    dv = 8'hA5;
    cycle();
    tests_run++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0 || drop_count !== 32'd0 ||
        error !== 1'b0 || o_discard !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_status: got gv=%b id=%0d drop=%0d err=%b disc=%b, want 0s",
               grant_valid, grant_id, drop_count, error, o_discard);
    end
    tests_run++;
    if (o_avail !== 4'h0 || o_empty !== 4'hF || o_rd_en !== 1'b0 || o_dv !== 8'hA5) begin
      tests_failed++;
      $display("FAIL midreset_route: got avail=%h empty=%h rd=%b dv=%h, want 0/F/0/a5",
               o_avail, o_empty, o_rd_en, o_dv);
    end
    rst_n = 1'b1; avail = 1'b0; empty = 1'b1; erd = '0; busy = '0;
    model_ptr = N - 1;
    cycle();
    run_packet('0, 3, '0, gid, rd_cnt, bad, granted);
    tests_run++;
    if (!granted || gid != 0 || rd_cnt != 3) begin
      tests_failed++;
      $display("FAIL after_reset_grant: got id=%0d rd=%0d, want 0/3", gid, rd_cnt);
    end
    model_ptr = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] bg, noise;
    int exp_id, n, gid, rd_cnt, bad;
    bit granted;
    logic [31:0] d0;
    d0 = drop_count;
    for (int it = 0; it < 12; it++) begin
      bg = N'($urandom);
      if (bg == '1) bg[$urandom_range(0, N - 1)] = 1'b0;
      noise = N'($urandom);
      n = $urandom_range(1, 8);
      exp_id = model_pick(bg);
      run_packet(bg, n, noise, gid, rd_cnt, bad, granted);
      tests_run++;
      if (!granted || gid != exp_id) begin
        tests_failed++;
        $display("FAIL rand_grant[%0d]: got %0d, want %0d (busy=%b)", it, gid, exp_id, bg);
      end
      tests_run++;
      if (rd_cnt != n || bad != 0) begin
        tests_failed++;
        $display("FAIL rand_route[%0d]: got rd=%0d bad=%0d, want %0d/0", it, rd_cnt, bad, n);
      end
      model_ptr = exp_id;
    end
    tests_run++;
    if (drop_count !== d0) begin
      tests_failed++;
      $display("FAIL rand_drop: got %0d, want %0d", drop_count, d0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_idle_timeout();
    test_accept_timeout();
    test_reset_mid_copy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
